// File: rtl/lut_ff_mux_sched.sv
// Round-robin scheduler sharing one lut_ff_mux datapath among NUM_REQ
// requesters; one op in flight, result returned over a valid/ready channel.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   req_valid     per-requester operation valid
//   req_ready     per-requester accept, one-hot or zero
//   req_in        operand of requester i at [4i+3:4i]
//   req_sel       mux_sel requested by requester i
//   dp_in         operand driven to the datapath
//   dp_mux_sel    mux_sel driven to the datapath
//   dp_q          datapath output Q
//   resp_valid    result available
//   resp_ready    consumer accepts result
//   resp_id       requester that owns the result
//   resp_data     sampled dp_q
//   busy          high while an op is in RUN or RESP
//   done_cnt      completed transactions, wraps silently
module lut_ff_mux_sched #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int LAT_REG  = 2,
  parameter int LAT_COMB = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_in,
  input  logic [NUM_REQ-1:0]   req_sel,
  output logic [3:0]           dp_in,
  output logic                 dp_mux_sel,
  input  logic                 dp_q,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic                 resp_data,
  output logic                 busy,
  output logic [15:0]          done_cnt
);

  localparam int LAT_MAX =
    (LAT_REG > LAT_COMB) ? LAT_REG : LAT_COMB;
  localparam int CNT_W =
    (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_REG =
    CNT_W'(LAT_REG - 1);
  localparam logic [CNT_W-1:0] CNT_COMB =
    CNT_W'(LAT_COMB - 1);
  localparam logic [ID_W-1:0] LAST_INIT =
    ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP
  } state_t;

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] id;
  logic [CNT_W-1:0] cnt;

  logic [ID_W-1:0] grant;
  logic            grant_hit;
  logic [3:0]      grant_op;
  logic            grant_sel;
  logic            accept;

  // Search starts one past the last winner so every
  // requester is reached within NUM_REQ grants.
  always_comb begin
    int idx;
    grant     = '0;
    grant_hit = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ)
        idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_hit && i == idx
            && req_valid[i]) begin
          grant_hit = 1'b1;
          grant     = ID_W'(i);
        end
      end
    end
  end

  assign accept = (state == IDLE) && grant_hit && !rst;

  always_comb begin
    req_ready = '0;
    grant_op  = '0;
    grant_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        grant_op  = req_in[4*i +: 4];
        grant_sel = req_sel[i];
        req_ready[i] = accept;
      end
    end
  end

  // dp_in/dp_mux_sel double as the latched operation:
  // loaded on accept, untouched until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= LAST_INIT;
      id         <= '0;
      cnt        <= '0;
      dp_in      <= '0;
      dp_mux_sel <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= 1'b0;
      busy       <= 1'b0;
      done_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant;
            id         <= grant;
            cnt        <= grant_sel ? CNT_COMB
                                    : CNT_REG;
            dp_in      <= grant_op;
            dp_mux_sel <= grant_sel;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            resp_data  <= dp_q;
            resp_id    <= id;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            done_cnt   <= done_cnt + 16'd1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_ff_mux_sched.sv
// Directed bench for lut_ff_mux_sched with a parity-LUT
// datapath model (registered path for sel=0, bypass for sel=1).
module tb_lut_ff_mux_sched;

  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int LAT_REG  = 2;
  localparam int LAT_COMB = 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_in;
  logic [NUM_REQ-1:0]   req_sel;
  logic [3:0]           dp_in;
  logic                 dp_mux_sel;
  logic                 dp_q;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic                 resp_data;
  logic                 busy;
  logic [15:0]          done_cnt;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_done;

  always #5 clk = ~clk;

  lut_ff_mux_sched #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W),
    .LAT_REG (LAT_REG),
    .LAT_COMB(LAT_COMB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in    (req_in),
    .req_sel   (req_sel),
    .dp_in     (dp_in),
    .dp_mux_sel(dp_mux_sel),
    .dp_q      (dp_q),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_data (resp_data),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  function automatic logic lut_f(input logic [3:0] a);
    return ^a;
  endfunction

  logic dp_ff;
  always @(posedge clk) dp_ff <= lut_f(dp_in);
  assign dp_q = dp_mux_sel ? lut_f(dp_in) : dp_ff;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  typedef struct {
    int         id;
    logic [3:0] op;
    logic       sel;
    logic       exp_d;
    int         lat;
    int         hold;
  } vec_t;

  vec_t vt[8];

  task automatic do_op(input vec_t v);
    int cyc;
    req_in[4*v.id +: 4] = v.op;
    req_sel[v.id]       = v.sel;
    req_valid           = NUM_REQ'(1) << v.id;
    #1;
    chk("accept_ready", req_ready,
        32'(NUM_REQ'(1) << v.id));
    @(posedge clk); #1;
    req_valid = '0;
    cyc = 0;
    while (!resp_valid && cyc < 20) begin
      chk("run_dp_in", dp_in, v.op);
      chk("run_dp_sel", dp_mux_sel, v.sel);
      chk("run_busy", busy, 1);
      chk("run_ready", req_ready, 0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, v.lat);
    chk("resp_id", resp_id, v.id);
    chk("resp_data", resp_data, v.exp_d);
    chk("resp_dp_in", dp_in, v.op);
    for (int h = 0; h < v.hold; h++) begin
      req_valid = '1;
      #1;
      chk("bp_ready", req_ready, 0);
      @(posedge clk); #1;
      chk("bp_valid", resp_valid, 1);
      chk("bp_id", resp_id, v.id);
      chk("bp_data", resp_data, v.exp_d);
      chk("bp_done", done_cnt, exp_done);
    end
    req_valid  = '0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    exp_done   = exp_done + 16'd1;
    chk("done_cnt", done_cnt, exp_done);
    chk("resp_drop", resp_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int cyc;
    int kr;
    int kg;
    bit seen;
    int order[6];

    // id, op, sel, expected parity, latency, backpressure cycles
    vt[0] = '{0, 4'b0100, 1'b0, 1'b1, 2, 10};
    vt[1] = '{2, 4'b0001, 1'b1, 1'b1, 1, 0};
    vt[2] = '{1, 4'b0011, 1'b0, 1'b0, 2, 0};
    vt[3] = '{3, 4'b0111, 1'b0, 1'b1, 2, 0};
    vt[4] = '{0, 4'b1111, 1'b1, 1'b0, 1, 0};
    vt[5] = '{1, 4'b1011, 1'b0, 1'b1, 2, 0};
    vt[6] = '{2, 4'b1010, 1'b0, 1'b0, 2, 0};
    vt[7] = '{3, 4'b0000, 1'b1, 1'b0, 1, 0};
    order = '{0, 1, 2, 3, 0, 1};

    rst        = 1'b1;
    req_valid  = '1;
    req_in     = '0;
    req_sel    = '0;
    resp_ready = 1'b0;
    exp_done   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    req_valid = '0;
    rst       = 1'b0;
    #1;
    chk("init_ready", req_ready, 0);
    chk("init_dp_in", dp_in, 0);
    chk("init_dp_sel", dp_mux_sel, 0);
    chk("init_resp_valid", resp_valid, 0);
    chk("init_resp_id", resp_id, 0);
    chk("init_resp_data", resp_data, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done_cnt, 0);

    for (int i = 0; i < 8; i++)
      do_op(vt[i]);

    // all four requesters valid back to back
    req_in     = 16'h0000;
    req_sel    = '1;
    req_valid  = '1;
    resp_ready = 1'b1;
    #1;
    kr  = 0;
    kg  = 0;
    cyc = 0;
    while (kr < 6 && cyc < 100) begin
      if (req_ready != 0) begin
        if (kg < 6)
          chk("rr_grant", req_ready,
              32'(NUM_REQ'(1) << order[kg]));
        kg++;
      end
      if (resp_valid) begin
        chk("rr_resp_id", resp_id, order[kr]);
        kr++;
      end
      if (kr < 6) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("rr_count", kr, 6);
    req_valid = '0;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    exp_done   = exp_done + 16'd6;
    chk("rr_done", done_cnt, exp_done);

    // reset in the second RUN cycle of a registered op
    req_in[11:8] = 4'b0101;
    req_sel[2]   = 1'b0;
    req_valid    = 4'b0100;
    #1;
    chk("mid_accept", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk("mid_run2_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_done = '0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (resp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid_no_resp", seen, 0);
    chk("mid_busy", busy, 0);
    chk("mid_dp_in", dp_in, 0);
    chk("mid_done", done_cnt, 0);

    req_in     = {8'h00, 4'b0110, 4'b1001};
    req_sel    = 4'b0011;
    req_valid  = 4'b0011;
    resp_ready = 1'b1;
    #1;
    chk("post_rst_first", req_ready, 4'b0001);
    @(posedge clk); #1;
    cyc = 0;
    while (req_ready == 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("post_rst_second", req_ready, 4'b0010);
    chk("post_rst_done", done_cnt, 1);
    req_valid  = '0;
    resp_ready = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
